seg_p2s_display: RTL

- Output-side counterpart of the keypad/switch 32-bit entry path: takes a 32-bit value, a blink mask and a decimal-point mask, and transmits them to the board's serial 7-segment shift-register chain (8 digits × 8 segments = 64 bits).
- Handles hex-to-segment encoding, blink gating, serial clocking and the final latch pulse.
- Sits between the datapath display mux and the board pins (seg_clk / seg_sout / seg_load).

---
 rtl/seg_p2s_display_pkg.sv | 24 ++
 rtl/seg_p2s_display_if.sv | 21 ++
 rtl/seg_p2s_display_hex7seg.sv | 30 +++
 rtl/seg_p2s_display.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg_p2s_display_pkg.sv
// Shared types and constants for the serial 7-segment display driver.
// The frame holds eight active-low digit bytes ordered {dp,g,f,e,d,c,b,a}.
package seg_p2s_display_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         DIGITS     = 8;
    localparam int         FRAME_BITS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    // Forces the whole digit dark when blanked; otherwise prepends the active-low dp.
    function automatic logic [7:0] digit_byte(input logic [6:0] seg,
                                              input logic       dp_lit,
                                              input logic       blank);
        return blank ? SEG_BLANK : {~dp_lit, seg};
    endfunction

endpackage

// File: rtl/seg_p2s_display_if.sv
// Request/status bundle between the display mux and the serial display driver.
interface seg_p2s_display_if;

    logic        start;
    logic [31:0] disp_data;
    logic [7:0]  blink;
    logic [7:0]  point;
    logic        busy;
    logic        done;

    modport master (
        output start, disp_data, blink, point,
        input  busy, done
    );

    modport slave (
        input  start, disp_data, blink, point,
        output busy, done
    );

endinterface

// File: rtl/seg_p2s_display_hex7seg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg_p2s_display_hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_p2s_display.sv
// Serialises eight hex digits (with blink and decimal points) MSB first into the
// board's 64-bit 7-segment shift chain, then pulses the storage latch.
module seg_p2s_display
    import seg_p2s_display_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int BLINK_BITS = 24
) (
    input  logic             clk,
    input  logic             rstn,
    seg_p2s_display_if.slave bus,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_load
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LAST_BIT = 6'(FRAME_BITS - 1);

    state_t                state, state_nxt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_off;
    logic [FRAME_BITS-1:0] frame, frame_nxt, frame_cap;
    logic [5:0]            bit_cnt, bit_nxt;
    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic                  busy, busy_nxt;
    logic                  done, done_nxt;
    logic                  seg_clk_nxt, seg_sout_nxt, seg_load_nxt;
    logic [6:0]            seg7 [DIGITS];

    assign blink_off = blink_cnt[BLINK_BITS-1];
    assign bus.busy  = busy;
    assign bus.done  = done;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        seg_p2s_display_hex7seg u_hex (
            .nibble (bus.disp_data[4*i +: 4]),
            .seg    (seg7[i])
        );
        assign frame_cap[8*i +: 8] = digit_byte(seg7[i], bus.point[i], bus.blink[i] & blink_off);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        frame_nxt    = frame;
        bit_nxt      = bit_cnt;
        div_nxt      = div_cnt;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        seg_clk_nxt  = seg_clk;
        seg_sout_nxt = seg_sout;
        seg_load_nxt = seg_load;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                    busy_nxt  = 1'b1;
                end
            end
            LOAD: begin
                // First bit is presented together with the capture so its low phase starts at once.
                frame_nxt    = frame_cap;
                seg_sout_nxt = frame_cap[FRAME_BITS-1];
                bit_nxt      = LAST_BIT;
                div_nxt      = '0;
                seg_clk_nxt  = 1'b0;
                state_nxt    = SHIFT;
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (!seg_clk) begin
                        seg_clk_nxt = 1'b1;
                    end else begin
                        seg_clk_nxt = 1'b0;
                        if (bit_cnt == 6'd0) begin
                            seg_load_nxt = 1'b1;
                            state_nxt    = LATCH;
                        end else begin
                            bit_nxt      = bit_cnt - 6'd1;
                            seg_sout_nxt = frame[bit_cnt - 6'd1];
                        end
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt      = '0;
                    seg_load_nxt = 1'b0;
                    done_nxt     = 1'b1;
                    busy_nxt     = 1'b0;
                    state_nxt    = DONE;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                // A held start chains straight into the next frame.
                if (bus.start) begin
                    state_nxt = LOAD;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            frame    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            seg_load <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame    <= frame_nxt;
            bit_cnt  <= bit_nxt;
            div_cnt  <= div_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            seg_clk  <= seg_clk_nxt;
            seg_sout <= seg_sout_nxt;
            seg_load <= seg_load_nxt;
        end
    end

endmodule
